result_fifo: RTL and testbench

Buffers the per-instruction results produced by the execute/result stage and presents them, in order, to a slower downstream consumer such as a display or serial dumper. Each accepted entry is one executed instruction: {op, A, B, result}. The block sits directly after the result stage. It decouples the one-instruction-per-clock ALU path from a consumer that applies back-pressure. It also records sticky overflow and running-count status.

---
 rtl/result_fifo_if.sv | 26 ++
 rtl/result_fifo.sv | 96 +++++++++
 tb/tb_result_fifo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/result_fifo_if.sv
// Handshake bundle between the result stage, the result FIFO and its downstream consumer.
// The FIFO takes the slave view; the producer/consumer side takes the master view.
interface result_fifo_if;
  logic       in_valid;
  logic [2:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] in_res;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_op;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [7:0] out_res;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_res, out_ready,
    output in_ready, out_valid, out_op, out_a, out_b, out_res
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_res, out_ready,
    input  in_ready, out_valid, out_op, out_a, out_b, out_res
  );
endinterface

// File: rtl/result_fifo.sv
// In-order buffer of executed-instruction records {op, a, b, res} with first-word-fall-through
// read, plus sticky overflow and a wrapping count of accepted entries.
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  result_fifo_if.slave  bus,
  output logic [CW-1:0] count,
  output logic [7:0]    accepted,
  output logic          overflow
);
  localparam int AW = $clog2(DEPTH);

  typedef logic [26:0] entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      accepted_q, accepted_d;
  logic            overflow_q, overflow_d;
  logic            full, empty, push, pop;
  entry_t          head;

  // Handshake outputs come only from registered occupancy.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.in_valid & ~full;
  assign pop   = bus.out_ready & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    overflow_d = overflow_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    if (push) begin
      mem_d[wr_ptr_q] = {bus.in_op, bus.in_a, bus.in_b, bus.in_res};
      wr_ptr_d        = wr_ptr_q + AW'(1);
      accepted_d      = accepted_q + 8'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (bus.in_valid && full) begin
      overflow_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      accepted_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally left out of reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_op    = head[26:24];
  assign bus.out_a     = head[23:16];
  assign bus.out_b     = head[15:8];
  assign bus.out_res   = head[7:0];

  assign count    = count_q;
  assign accepted = accepted_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_result_fifo.sv
// Bench for result_fifo: directed stimulus with hand-computed checks, plus a queue scoreboard
// that a separate negedge monitor uses to check every presented head entry and status output.
module tb_result_fifo;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic [CW-1:0] count;
  logic [7:0]    accepted;
  logic          overflow;

  result_fifo_if bus();

  result_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .count    (count),
    .accepted (accepted),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected entries in acceptance order plus expected status counters.
  logic [26:0] sb_q[$];
  logic [7:0]  m_acc = 8'd0;
  logic        m_ovf = 1'b0;

  always @(negedge clk) begin
    logic do_push, do_pop;
    if (reset) begin
      sb_q.delete();
      m_acc = 8'd0;
      m_ovf = 1'b0;
    end else begin
      check("mon_out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
      check("mon_in_ready",  32'(bus.in_ready),  32'(sb_q.size() != DEPTH));
      check("mon_count",     32'(count),         32'(sb_q.size()));
      check("mon_accepted",  32'(accepted),      32'(m_acc));
      check("mon_overflow",  32'(overflow),      32'(m_ovf));
      if (sb_q.size() != 0)
        check("mon_head", 32'({bus.out_op, bus.out_a, bus.out_b, bus.out_res}), 32'(sb_q[0]));
      else
        check("mon_head_zero", 32'({bus.out_op, bus.out_a, bus.out_b, bus.out_res}), 32'd0);
      do_pop  = bus.out_ready && (sb_q.size() != 0);
      do_push = bus.in_valid  && (sb_q.size() != DEPTH);
      if (bus.in_valid && sb_q.size() == DEPTH) m_ovf = 1'b1;
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) begin
        sb_q.push_back({bus.in_op, bus.in_a, bus.in_b, bus.in_res});
        m_acc = m_acc + 8'd1;
      end
    end
  end

  // Apply inputs now, hold them across one rising edge, return 2 time units after it.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] r, input logic rdy);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_res    = r;
    bus.out_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_res    = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    // Reset then idle
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_count",     32'(count),         32'd0);
    check("rst_accepted",  32'(accepted),      32'd0);
    check("rst_overflow",  32'(overflow),      32'd0);
    check("rst_out_res",   32'(bus.out_res),   32'd0);

    // Single entry
    cyc(1'b1, 3'd0, 8'h17, 8'h13, 8'h2A, 1'b0);
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_a",     32'(bus.out_a),     32'h17);
    check("single_b",     32'(bus.out_b),     32'h13);
    check("single_res",   32'(bus.out_res),   32'h2A);
    check("single_count", 32'(count),         32'd1);
    check("single_acc",   32'(accepted),      32'd1);
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("single_pop_valid", 32'(bus.out_valid), 32'd0);
    check("single_pop_count", 32'(count),         32'd0);

    // Fill and overflow
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 3'(i), 8'(i), 8'(8'hF0 + i), 8'(i), 1'b0);
      if (i == 8) check("fill_in_ready", 32'(bus.in_ready), 32'd0);
      if (i == 8) check("fill_ovf_early", 32'(overflow), 32'd0);
    end
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_count",    32'(count),    32'd8);
    check("fill_accepted", 32'(accepted), 32'd9);
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("drain_res", 32'(bus.out_res), 32'(i));
      cyc(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    end
    check("drain_empty", 32'(bus.out_valid), 32'd0);
    check("drain_res0",  32'(bus.out_res),   32'd0);

    // Concurrent push/pop at count = 3 across pointer wrap
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'd2, 8'h11, 8'h22, 8'(8'h40 + i), 1'b0);
    check("conc_start_count", 32'(count), 32'd3);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 3'd3, 8'(k), 8'(k + 1), 8'(8'h43 + k), 1'b1);
      check("conc_count", 32'(count), 32'd3);
    end
    check("conc_accepted", 32'(accepted), 32'd32);
    check("conc_head",     32'(bus.out_res), 32'h54);

    // Full plus pop, from a clean state
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    reset = 1'b0;
    check("fp_rst_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'd5, 8'hAA, 8'h55, 8'(8'h60 + i), 1'b0);
    check("fp_full_ready", 32'(bus.in_ready), 32'd0);
    check("fp_full_ovf",   32'(overflow),     32'd0);
    cyc(1'b1, 3'd7, 8'hEE, 8'hDD, 8'h77, 1'b1);
    check("fp_count",    32'(count),        32'd7);
    check("fp_overflow", 32'(overflow),     32'd1);
    check("fp_ready",    32'(bus.in_ready), 32'd1);
    check("fp_accepted", 32'(accepted),     32'd8);
    check("fp_head",     32'(bus.out_res),  32'h61);
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    check("fp_idle_count", 32'(count), 32'd7);

    // Reset mid-stream with count = 5
    repeat (2) cyc(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    check("mid_count5", 32'(count), 32'd5);
    reset = 1'b1;
    cyc(1'b1, 3'd1, 8'h01, 8'h02, 8'h03, 1'b1);
    reset = 1'b0;
    check("mid_count",     32'(count),         32'd0);
    check("mid_accepted",  32'(accepted),      32'd0);
    check("mid_overflow",  32'(overflow),      32'd0);
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_in_ready",  32'(bus.in_ready),  32'd1);
    cyc(1'b1, 3'd4, 8'h12, 8'h34, 8'h99, 1'b0);
    check("post_res", 32'(bus.out_res), 32'h99);
    check("post_acc", 32'(accepted),    32'd1);
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
